// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the control bundle carried from ID through EX/MEM.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_load_use.sv
// Load-use hazard detect: a load in EX whose destination is a source of the ID instruction.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       i_mem_read_ex,
  input  logic       i_valid_ex,
  input  logic [4:0] i_rt_ex,
  input  logic       i_valid_id,
  input  logic [4:0] i_rs_id,
  input  logic [4:0] i_rt_id,
  output logic       o_lu
);

  logic w_src_match;

  assign w_src_match = (i_rt_ex == i_rs_id) | (i_rt_ex == i_rt_id);

  // A load targeting $zero never produces a value worth waiting for.
  assign o_lu = i_mem_read_ex & i_valid_ex & (i_rt_ex != REG_ZERO) &
                i_valid_id & w_src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external hold.
// Optional macro HAZARD_STATS_EN adds a saturating load-use bubble counter (bubble_cnt).
module id_ex_stage_reg #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               flush,
  input  logic               valid_id,
  input  logic [4:0]         rs_id,
  input  logic [4:0]         rt_id,
  input  logic [4:0]         rd_id,
  input  logic [DATA_W-1:0]  rdata1_id,
  input  logic [DATA_W-1:0]  rdata2_id,
  input  logic [DATA_W-1:0]  imm_id,
  input  logic [DATA_W-1:0]  pc4_id,
  input  logic               regWrite_id,
  input  logic               memRead_id,
  input  logic               memWrite_id,
  input  logic               memToReg_id,
  input  logic               regDst_id,
  input  logic               aluSrc_id,
  input  logic [ALUOP_W-1:0] aluOp_id,
  output logic               valid_ex,
  output logic [4:0]         rs_ex,
  output logic [4:0]         rt_ex,
  output logic [4:0]         write_reg_ex,
  output logic [DATA_W-1:0]  rdata1_ex,
  output logic [DATA_W-1:0]  rdata2_ex,
  output logic [DATA_W-1:0]  imm_ex,
  output logic [DATA_W-1:0]  pc4_ex,
  output logic               regWrite_ex,
  output logic               memRead_ex,
  output logic               memWrite_ex,
  output logic               memToReg_ex,
  output logic               aluSrc_ex,
  output logic [ALUOP_W-1:0] aluOp_ex,
`ifdef HAZARD_STATS_EN
  output logic [15:0]        bubble_cnt,
`endif
  output logic               pc_write,
  output logic               ifid_write
);

  import mips_pkg::*;

  logic              r_valid;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_wr;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  ctrl_t             r_ctrl;

  logic  w_lu;
  logic  w_bubble;
  ctrl_t w_ctrl_next;

  load_use_detect u_load_use_detect (
    .i_mem_read_ex (r_ctrl.mem_read),
    .i_valid_ex    (r_valid),
    .i_rt_ex       (r_rt),
    .i_valid_id    (valid_id),
    .i_rs_id       (rs_id),
    .i_rt_id       (rt_id),
    .o_lu          (w_lu)
  );

  assign w_bubble = flush | w_lu;

  // Bubbles only need the side-effecting bits cleared; the rest load from ID.
  always_comb begin
    w_ctrl_next            = '0;
    w_ctrl_next.reg_write  = regWrite_id & valid_id & ~w_bubble;
    w_ctrl_next.mem_read   = memRead_id  & valid_id & ~w_bubble;
    w_ctrl_next.mem_write  = memWrite_id & valid_id & ~w_bubble;
    w_ctrl_next.mem_to_reg = memToReg_id & valid_id;
    w_ctrl_next.alu_src    = aluSrc_id   & valid_id;
    w_ctrl_next.alu_op     = valid_id ? aluOp_id : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_wr     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
      r_ctrl   <= '0;
    end else if (!hold) begin
      r_valid  <= valid_id & ~w_bubble;
      r_rs     <= rs_id;
      r_rt     <= rt_id;
      r_wr     <= regDst_id ? rd_id : rt_id;
      r_rdata1 <= rdata1_id;
      r_rdata2 <= rdata2_id;
      r_imm    <= imm_id;
      r_pc4    <= pc4_id;
      r_ctrl   <= w_ctrl_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_bubble_cnt;

  // Only load-use bubbles are counted; flush-induced ones are excluded.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_bubble_cnt <= '0;
    else if (w_lu && !hold && !flush && r_bubble_cnt != 16'hFFFF)
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  assign valid_ex     = r_valid;
  assign rs_ex        = r_rs;
  assign rt_ex        = r_rt;
  assign write_reg_ex = r_wr;
  assign rdata1_ex    = r_rdata1;
  assign rdata2_ex    = r_rdata2;
  assign imm_ex       = r_imm;
  assign pc4_ex       = r_pc4;
  assign regWrite_ex  = r_ctrl.reg_write;
  assign memRead_ex   = r_ctrl.mem_read;
  assign memWrite_ex  = r_ctrl.mem_write;
  assign memToReg_ex  = r_ctrl.mem_to_reg;
  assign aluSrc_ex    = r_ctrl.alu_src;
  assign aluOp_ex     = r_ctrl.alu_op;

  assign pc_write   = ~(w_lu | hold);
  assign ifid_write = ~(w_lu | hold);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard scenarios plus random traffic vs a behavioural model.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, hold, flush, valid_id;
  logic [4:0]    rs_id, rt_id, rd_id;
  logic [DW-1:0] rdata1_id, rdata2_id, imm_id, pc4_id;
  logic          regWrite_id, memRead_id, memWrite_id, memToReg_id, regDst_id, aluSrc_id;
  logic [AW-1:0] aluOp_id;

  logic          valid_ex;
  logic [4:0]    rs_ex, rt_ex, write_reg_ex;
  logic [DW-1:0] rdata1_ex, rdata2_ex, imm_ex, pc4_ex;
  logic          regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex, aluSrc_ex;
  logic [AW-1:0] aluOp_ex;
  logic          pc_write, ifid_write;
`ifdef HAZARD_STATS_EN
  logic [15:0]   bubble_cnt;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .valid_id(valid_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc4_id(pc4_id),
    .regWrite_id(regWrite_id), .memRead_id(memRead_id), .memWrite_id(memWrite_id),
    .memToReg_id(memToReg_id), .regDst_id(regDst_id), .aluSrc_id(aluSrc_id), .aluOp_id(aluOp_id),
    .valid_ex(valid_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .write_reg_ex(write_reg_ex),
    .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex), .pc4_ex(pc4_ex),
    .regWrite_ex(regWrite_ex), .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
    .memToReg_ex(memToReg_ex), .aluSrc_ex(aluSrc_ex), .aluOp_ex(aluOp_ex),
`ifdef HAZARD_STATS_EN
    .bubble_cnt(bubble_cnt),
`endif
    .pc_write(pc_write), .ifid_write(ifid_write)
  );

  // Expected EX-stage contents of the instruction currently in EX.
  typedef struct {
    logic          valid;
    logic [4:0]    rs, rt, wr;
    logic [DW-1:0] d1, d2, imm, pc4;
    logic          rw, mr, mw, m2r, as;
    logic [AW-1:0] op;
  } ex_t;

  ex_t         m, nx;
  bit          m_bub, m_init;
  logic [15:0] m_cnt;
  int          n_chk, n_fail;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_lu();
    return m.mr && m.valid && (m.rt != 5'd0) && valid_id && (m.rt == rs_id || m.rt == rt_id);
  endfunction

  task automatic check_ex();
    if (!m_init) return;
    check_val("valid_ex", valid_ex, m.valid);
    check_val("regWrite_ex", regWrite_ex, m.rw);
    check_val("memRead_ex", memRead_ex, m.mr);
    check_val("memWrite_ex", memWrite_ex, m.mw);
    if (!m_bub) begin
      check_val("rs_ex", rs_ex, m.rs);
      check_val("rt_ex", rt_ex, m.rt);
      check_val("write_reg_ex", write_reg_ex, m.wr);
      check_val("rdata1_ex", rdata1_ex, m.d1);
      check_val("rdata2_ex", rdata2_ex, m.d2);
      check_val("imm_ex", imm_ex, m.imm);
      check_val("pc4_ex", pc4_ex, m.pc4);
      check_val("memToReg_ex", memToReg_ex, m.m2r);
      check_val("aluSrc_ex", aluSrc_ex, m.as);
      check_val("aluOp_ex", aluOp_ex, m.op);
    end
`ifdef HAZARD_STATS_EN
    check_val("bubble_cnt", bubble_cnt, m_cnt);
`endif
  endtask

  // Inputs must already be applied (just after a falling edge) when step is called.
  task automatic step();
    logic lu;
    bit   nb;
    #1;
    lu = m_init ? model_lu() : 1'b0;
    if (m_init) begin
      check_val("pc_write", pc_write, !(lu || hold));
      check_val("ifid_write", ifid_write, !(lu || hold));
    end
    nb = 1'b0;
    if (!rst_n) begin
      nx = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, wr: 5'd0, d1: '0, d2: '0, imm: '0, pc4: '0,
             rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, as: 1'b0, op: '0};
    end else if (hold) begin
      nx = m;
      nb = m_bub;
    end else begin
      nx.rs    = rs_id;
      nx.rt    = rt_id;
      nx.wr    = regDst_id ? rd_id : rt_id;
      nx.d1    = rdata1_id;
      nx.d2    = rdata2_id;
      nx.imm   = imm_id;
      nx.pc4   = pc4_id;
      nx.valid = valid_id;
      nx.rw    = regWrite_id && valid_id;
      nx.mr    = memRead_id && valid_id;
      nx.mw    = memWrite_id && valid_id;
      nx.m2r   = memToReg_id && valid_id;
      nx.as    = aluSrc_id && valid_id;
      nx.op    = valid_id ? aluOp_id : '0;
      if (flush || lu) begin
        nx.valid = 1'b0;
        nx.rw    = 1'b0;
        nx.mr    = 1'b0;
        nx.mw    = 1'b0;
        nb       = 1'b1;
      end
    end
    if (!rst_n) m_cnt = 16'd0;
    else if (lu && !hold && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(posedge clk);
    m     = nx;
    m_bub = nb;
    if (!rst_n) m_init = 1'b1;
    @(negedge clk);
    check_ex();
  endtask

  task automatic id_instr(input logic v, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic rdst, input logic as);
    valid_id = v;  rs_id = s;  rt_id = t;  rd_id = d;
    regWrite_id = rw;  memRead_id = mr;  memWrite_id = mw;
    memToReg_id = m2r; regDst_id = rdst; aluSrc_id = as;
    aluOp_id  = AW'($urandom);
    rdata1_id = $urandom;  rdata2_id = $urandom;
    imm_id    = $urandom;  pc4_id    = $urandom;
  endtask

  task automatic rand_id();
    id_instr(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 1) == 0),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  logic [DW-1:0] sv_d1;
  logic [4:0]    sv_wr;

  initial begin
    n_chk = 0; n_fail = 0; m_init = 1'b0; m_bub = 1'b0; m_cnt = 16'd0;

    // Reset with busy inputs (hold kept low so pc_write reflects lu alone)
    rst_n = 1'b0; hold = 1'b0; flush = 1'b1;
    id_instr(1, 5'd31, 5'd30, 5'd29, 1, 1, 1, 1, 1, 1);
    step();
    step();
    check_val("rst_pc_write", pc_write, 1'b1);
    check_val("rst_valid_ex", valid_ex, 1'b0);
    rst_n = 1'b1; flush = 1'b0;

    // lw $8,0($9) then add $10,$8,$11
    id_instr(1, 5'd9, 5'd8, 5'd0, 1, 1, 0, 1, 0, 1);
    step();
    id_instr(1, 5'd8, 5'd11, 5'd10, 1, 0, 0, 0, 1, 0);
    #1 check_val("lu_pc_write", pc_write, 1'b0);
    step();
    check_val("lu_bubble_valid", valid_ex, 1'b0);
    check_val("lu_bubble_rw", regWrite_ex, 1'b0);
    step();
    check_val("lu_rs_ex", rs_ex, 5'd8);
    check_val("lu_rt_ex", rt_ex, 5'd11);
    check_val("lu_wr_ex", write_reg_ex, 5'd10);
    check_val("lu_rw_ex", regWrite_ex, 1'b1);

    // Load to $0 never stalls
    id_instr(1, 5'd4, 5'd0, 5'd0, 1, 1, 0, 1, 0, 1);
    step();
    id_instr(1, 5'd0, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
    #1 check_val("zero_pc_write", pc_write, 1'b1);
    step();

    // Flush of a store, then flush coinciding with load-use
    id_instr(1, 5'd3, 5'd4, 5'd0, 0, 0, 1, 0, 0, 1);
    flush = 1'b1;
    step();
    check_val("flush_mw_ex", memWrite_ex, 1'b0);
    check_val("flush_valid_ex", valid_ex, 1'b0);
    flush = 1'b0;
    id_instr(1, 5'd2, 5'd5, 5'd0, 1, 1, 0, 1, 0, 1);
    step();
    id_instr(1, 5'd5, 5'd1, 5'd7, 1, 0, 0, 0, 1, 0);
    flush = 1'b1;
    #1 check_val("flu_pc_write", pc_write, 1'b0);
    step();
    check_val("flu_valid_ex", valid_ex, 1'b0);
    flush = 1'b0;
    id_instr(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 0);
    #1 check_val("flu_after_pc", pc_write, 1'b1);
    step();
    check_val("flu_after_valid", valid_ex, 1'b1);

    // Hold for 3 cycles while ID changes
    id_instr(1, 5'd6, 5'd7, 5'd12, 1, 0, 0, 0, 1, 0);
    step();
    sv_d1 = rdata1_ex; sv_wr = write_reg_ex;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      check_val("hold_d1", rdata1_ex, sv_d1);
      check_val("hold_wr", write_reg_ex, sv_wr);
    end
    hold = 1'b0;
    id_instr(1, 5'd13, 5'd14, 5'd15, 1, 0, 0, 0, 1, 0);
    step();
    check_val("release_rs", rs_ex, 5'd13);
    check_val("release_wr", write_reg_ex, 5'd15);

`ifdef HAZARD_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_instr(1, 5'd2, 5'd5, 5'd0, 1, 1, 0, 1, 0, 1);
      step();
      id_instr(1, 5'd5, 5'd1, 5'd7, 1, 0, 0, 0, 1, 0);
      step();
    end
    flush = 1'b1;
    id_instr(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 0);
    step();
    flush = 1'b0;
    check_val("stats_cnt3", bubble_cnt, 16'd3);
    force dut.r_bubble_cnt = 16'hFFFE;
    #1 release dut.r_bubble_cnt;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      id_instr(1, 5'd2, 5'd5, 5'd0, 1, 1, 0, 1, 0, 1);
      step();
      id_instr(1, 5'd5, 5'd1, 5'd7, 1, 0, 0, 0, 1, 0);
      step();
    end
    check_val("stats_sat", bubble_cnt, 16'hFFFF);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rand_id();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
